// File: rtl/alu_sequencer.sv
// Collects operand A, operand B and opcode from a valid/ready word stream, drives them
// registered onto the shared ALU, captures the result and holds it on a valid/ready port.
module alu_sequencer #(
  parameter int NB_OPERANDO = 8,
  parameter int NB_OPCODE   = 6,
  parameter int NB_COUNT    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   abort,
  input  logic [NB_OPERANDO-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [NB_OPERANDO-1:0] alu_dato_a,
  output logic [NB_OPERANDO-1:0] alu_dato_b,
  output logic [NB_OPCODE-1:0]   alu_opcode,
  input  logic [NB_OPERANDO-1:0] alu_out,
  output logic [NB_OPERANDO-1:0] res_data,
  output logic                   res_err,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [NB_COUNT-1:0]    op_count
);

  typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_RESP} state_t;

  state_t                 state_q, state_d;
  logic [NB_OPERANDO-1:0] dato_a_q, dato_a_d;
  logic [NB_OPERANDO-1:0] dato_b_q, dato_b_d;
  logic [NB_OPCODE-1:0]   opcode_q, opcode_d;
  logic [NB_OPERANDO-1:0] res_data_q, res_data_d;
  logic                   res_err_q, res_err_d;
  logic                   res_valid_q, res_valid_d;
  logic                   in_ready_q, in_ready_d;
  logic [NB_COUNT-1:0]    op_count_q, op_count_d;
  logic                   xfer;

  function automatic logic is_legal(input logic [NB_OPCODE-1:0] op);
    logic ok;
    ok = 1'b0;
    if (op == NB_OPCODE'(6'b100000) || op == NB_OPCODE'(6'b100010) ||
        op == NB_OPCODE'(6'b100100) || op == NB_OPCODE'(6'b100101) ||
        op == NB_OPCODE'(6'b100110) || op == NB_OPCODE'(6'b000011) ||
        op == NB_OPCODE'(6'b000010) || op == NB_OPCODE'(6'b100111))
      ok = 1'b1;
    return ok;
  endfunction

  assign xfer = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    dato_a_d    = dato_a_q;
    dato_b_d    = dato_b_q;
    opcode_d    = opcode_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    op_count_d  = op_count_q;
    // abort discards any transfer or handoff happening in the same cycle
    if (abort) begin
      state_d     = S_A;
      res_valid_d = 1'b0;
      res_err_d   = 1'b0;
    end else begin
      case (state_q)
        S_A: if (xfer) begin
          dato_a_d = in_data;
          state_d  = S_B;
        end
        S_B: if (xfer) begin
          dato_b_d = in_data;
          state_d  = S_OP;
        end
        S_OP: if (xfer) begin
          opcode_d = in_data[NB_OPCODE-1:0];
          state_d  = S_EXEC;
        end
        S_EXEC: begin
          res_data_d  = is_legal(opcode_q) ? alu_out : '0;
          res_err_d   = !is_legal(opcode_q);
          res_valid_d = 1'b1;
          state_d     = S_RESP;
        end
        S_RESP: if (res_ready) begin
          res_valid_d = 1'b0;
          op_count_d  = op_count_q + NB_COUNT'(1);
          state_d     = S_A;
        end
        default: state_d = S_A;
      endcase
    end
    in_ready_d = (state_d == S_A) || (state_d == S_B) || (state_d == S_OP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_A;
      dato_a_q    <= '0;
      dato_b_q    <= '0;
      opcode_q    <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      dato_a_q    <= dato_a_d;
      dato_b_q    <= dato_b_d;
      opcode_q    <= opcode_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      in_ready_q  <= in_ready_d;
      op_count_q  <= op_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign alu_dato_a = dato_a_q;
  assign alu_dato_b = dato_b_q;
  assign alu_opcode = opcode_q;
  assign res_data   = res_data_q;
  assign res_err    = res_err_q;
  assign res_valid  = res_valid_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: table vectors, hand-written multi-cycle corner cases and
// random operations checked against an operation-level reference model.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset, abort, in_valid, in_ready, res_err, res_valid, res_ready;
  logic [7:0] in_data, alu_dato_a, alu_dato_b, alu_out, res_data, op_count;
  logic [5:0] alu_opcode;

  int n_pass = 0;
  int n_total = 0;
  int exp_count = 0;

  alu_sequencer #(.NB_OPERANDO(8), .NB_OPCODE(6), .NB_COUNT(8)) dut (
    .clk(clk), .reset(reset), .abort(abort), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .alu_dato_a(alu_dato_a), .alu_dato_b(alu_dato_b),
    .alu_opcode(alu_opcode), .alu_out(alu_out), .res_data(res_data), .res_err(res_err),
    .res_valid(res_valid), .res_ready(res_ready), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // External ALU; returns a junk pattern for unsupported opcodes
  always_comb begin
    case (alu_opcode)
      6'h20:   alu_out = alu_dato_a + alu_dato_b;
      6'h22:   alu_out = alu_dato_a - alu_dato_b;
      6'h24:   alu_out = alu_dato_a & alu_dato_b;
      6'h25:   alu_out = alu_dato_a | alu_dato_b;
      6'h26:   alu_out = alu_dato_a ^ alu_dato_b;
      6'h03:   alu_out = $unsigned($signed(alu_dato_a) >>> alu_dato_b);
      6'h02:   alu_out = alu_dato_a >> alu_dato_b;
      6'h27:   alu_out = ~(alu_dato_a | alu_dato_b);
      default: alu_out = 8'hA5;
    endcase
  end

  function automatic void ref_op(input logic [7:0] a, input logic [7:0] b,
                                 input logic [5:0] op, output logic [7:0] d,
                                 output logic e);
    int sa;
    sa = int'($signed(a));
    e  = 1'b0;
    case (op)
      6'h20: d = 8'((int'(a) + int'(b)) % 256);
      6'h22: d = 8'((int'(a) - int'(b) + 256) % 256);
      6'h24: d = a & b;
      6'h25: d = a | b;
      6'h26: d = a ^ b;
      6'h03: d = (b >= 8) ? (a[7] ? 8'hFF : 8'h00) : 8'(sa / (1 << b) - ((sa < 0 && sa % (1 << b) != 0) ? 1 : 0));
      6'h02: d = (b >= 8) ? 8'h00 : 8'(int'(a) / (1 << b));
      6'h27: d = 8'(255 - int'(a | b));
      default: begin d = 8'h00; e = 1'b1; end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] w, output int waited);
    in_data  = w;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) chk("xfer_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Full operation; stall cycles present a stray word with in_valid high
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                        input int stall);
    logic [7:0] ed;
    logic       ee;
    int         w;
    ref_op(a, b, op, ed, ee);
    res_ready = 1'b0;
    xfer(a, w);
    xfer(b, w);
    xfer({2'b00, op}, w);
    chk("exec_valid", res_valid, 0);
    chk("exec_ready", in_ready, 0);
    tick();
    chk("resp_valid", res_valid, 1);
    chk("resp_data", res_data, ed);
    chk("resp_err", res_err, ee);
    chk("resp_count", op_count, exp_count);
    in_data  = 8'h5A;
    in_valid = (stall > 0);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", res_valid, 1);
      chk("stall_data", res_data, ed);
      chk("stall_ready", in_ready, 0);
    end
    chk("hold_a", alu_dato_a, a);
    chk("hold_b", alu_dato_b, b);
    chk("hold_op", alu_opcode, op);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    in_valid  = 1'b0;
    exp_count = (exp_count + 1) % 256;
    chk("handoff_count", op_count, exp_count);
    chk("handoff_valid", res_valid, 0);
    chk("handoff_ready", in_ready, 1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] legal_ops[8];
    logic [5:0] op;
    logic [7:0] a, b, ed, keep_op;
    logic       ee;
    int         w;

    legal_ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};
    vecs[0] = '{8'h05, 8'h03, 6'h20, 8'h08, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 6'h22, 8'hFE, 1'b0};
    vecs[2] = '{8'hF0, 8'h0F, 6'h27, 8'h00, 1'b0};
    vecs[3] = '{8'h11, 8'h22, 6'h3F, 8'h00, 1'b1};
    vecs[4] = '{8'hF0, 8'h3C, 6'h24, 8'h30, 1'b0};
    vecs[5] = '{8'hF0, 8'h0F, 6'h25, 8'hFF, 1'b0};
    vecs[6] = '{8'hFF, 8'h0F, 6'h26, 8'hF0, 1'b0};
    vecs[7] = '{8'h80, 8'h01, 6'h02, 8'h40, 1'b0};
    vecs[8] = '{8'h80, 8'h01, 6'h03, 8'hC0, 1'b0};

    reset = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00; res_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", res_valid, 0);
    chk("rst_err", res_err, 0);
    chk("rst_data", res_data, 0);
    chk("rst_count", op_count, 0);
    chk("rst_a", alu_dato_a, 0);
    chk("rst_op", alu_opcode, 0);

    // Table vectors: data/err checked against hand-derived values
    for (int i = 0; i < 9; i++) begin
      xfer(vecs[i].a, w);
      xfer(vecs[i].b, w);
      xfer({2'b00, vecs[i].op}, w);
      tick();
      chk("vec_valid", res_valid, 1);
      chk($sformatf("vec%0d_data", i), res_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), res_err, vecs[i].exp_err);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      exp_count++;
      chk($sformatf("vec%0d_count", i), op_count, exp_count);
    end

    // Long stall, then next A accepted without waiting
    run_op(8'h21, 8'h13, 6'h22, 10);
    xfer(8'h09, w);
    chk("next_a_wait", w, 0);
    chk("next_a_val", alu_dato_a, 8'h09);
    xfer(8'h01, w);
    xfer(8'h20, w);
    tick();
    chk("next_a_res", res_data, 8'h0A);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_count++;

    // Abort in S_OP: opcode word discarded, operand registers kept
    xfer(8'h44, w);
    xfer(8'h55, w);
    keep_op  = {2'b00, alu_opcode};
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h26;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort_op_ready", in_ready, 1);
    chk("abort_op_opcode", alu_opcode, keep_op);
    chk("abort_op_a", alu_dato_a, 8'h44);
    run_op(8'h07, 8'h02, 6'h20, 0);

    // Abort in S_RESP beats res_ready
    xfer(8'h01, w);
    xfer(8'h02, w);
    xfer(8'h3E, w);
    tick();
    chk("abort_resp_pre", res_valid, 1);
    abort     = 1'b1;
    res_ready = 1'b1;
    tick();
    abort     = 1'b0;
    res_ready = 1'b0;
    chk("abort_resp_valid", res_valid, 0);
    chk("abort_resp_err", res_err, 0);
    chk("abort_resp_count", op_count, exp_count);
    chk("abort_resp_ready", in_ready, 1);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      a  = 8'($urandom);
      b  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 7)];
      run_op(a, b, op, $urandom_range(0, 3));
    end

    // Counter wrap
    while (exp_count != 255) run_op(8'($urandom), 8'($urandom), 6'h20, 0);
    chk("pre_wrap", op_count, 255);
    run_op(8'h01, 8'h01, 6'h25, 0);
    chk("wrap", op_count, 0);

    // Reset while waiting for B
    run_op(8'h02, 8'h02, 6'h20, 0);
    xfer(8'h12, w);
    chk("mid_b_a", alu_dato_a, 8'h12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_count = 0;
    chk("midrst_a", alu_dato_a, 0);
    chk("midrst_count", op_count, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_valid", res_valid, 0);
    chk("midrst_data", res_data, 0);
    chk("midrst_op", alu_opcode, 0);
    ref_op(8'h30, 8'h0F, 6'h26, ed, ee);
    run_op(8'h30, 8'h0F, 6'h26, 1);
    chk("post_rst_ref", ed, 8'h3F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
